// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the snake game-logic engine.
//   dir_t    : movement direction (right, down, left, up)
//   coord_t  : one grid cell {x, y} on the 16x16 board
//   state_t  : engine FSM states
//   step_coord / edge_hit : one-cell move helpers
package snake_pkg;

  localparam int unsigned GRID_DIM = 16;
  localparam int unsigned COORD_W  = 4;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_SNAKE = 3'b010;
  localparam logic [COLOUR_W-1:0] COLOUR_BG    = 3'b000;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [2:0] {
    S_RESET_WAIT = 3'd0,
    S_INIT_DRAW  = 3'd1,
    S_IDLE       = 3'd2,
    S_NEXT       = 3'd3,
    S_SCAN       = 3'd4,
    S_ERASE      = 3'd5,
    S_DRAW       = 3'd6,
    S_OVER       = 3'd7
  } state_t;

  // One cell in direction d; 4-bit arithmetic gives the mod-16 wrap.
  function automatic coord_t step_coord(input coord_t c, input dir_t d);
    coord_t n;
    n = c;
    case (d)
      DIR_RIGHT: n.x = c.x + COORD_W'(1);
      DIR_DOWN:  n.y = c.y + COORD_W'(1);
      DIR_LEFT:  n.x = c.x - COORD_W'(1);
      default:   n.y = c.y - COORD_W'(1);
    endcase
    return n;
  endfunction

  // High when a move from c in direction d would leave the grid.
  function automatic logic edge_hit(input coord_t c, input dir_t d);
    logic [COORD_W-1:0] last;
    last = COORD_W'(GRID_DIM - 1);
    case (d)
      DIR_RIGHT: return c.x == last;
      DIR_DOWN:  return c.y == last;
      DIR_LEFT:  return c.x == '0;
      default:   return c.y == '0;
    endcase
  endfunction

endpackage

// File: rtl/snake_seg_ram.sv
// snake_seg_ram: circular body-segment store, MAX_LEN x coord_t.
//   clk, rst            : clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i: single write port
//   raddr_i/rdata_o     : combinational read port
// Reset loads the initial straight snake: head (8,8) at INIT_LEN-1,
// each lower address one column further left.
module snake_seg_ram
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned PTR_W    = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  coord_t           wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output coord_t           rdata_o
);

  coord_t mem_q [MAX_LEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        mem_q[i].x <= COORD_W'(9 + i - int'(INIT_LEN));
        mem_q[i].y <= COORD_W'(8);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/snake_engine.sv
// snake_engine: snake game logic feeding game_plot with single-cell commands.
//   clk, rst (sync, active-high), start, step, dir/dir_valid, food_x/food_y
//   plot_waitrequest                    : game_plot busy, low = accepted
//   game_plot/game_x/game_y/game_colour : plot command (held until accepted)
//   food_eaten (pulse), game_over (sticky), length, busy
// Optional feature: define SNAKE_WALL_DEATH_EN to end the game when the head
// would cross a grid edge instead of wrapping around.
module snake_engine
  import snake_pkg::*;
#(
  parameter int unsigned             MAX_LEN      = 32,
  parameter int unsigned             INIT_LEN     = 3,
  parameter logic [COLOUR_W-1:0]     SNAKE_COLOUR = COLOUR_SNAKE,
  parameter logic [COLOUR_W-1:0]     BG_COLOUR    = COLOUR_BG
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                step,
  input  logic [1:0]          dir,
  input  logic                dir_valid,
  input  logic [COORD_W-1:0]  food_x,
  input  logic [COORD_W-1:0]  food_y,
  input  logic                plot_waitrequest,
  output logic                game_plot,
  output logic [COORD_W-1:0]  game_x,
  output logic [COORD_W-1:0]  game_y,
  output logic [COLOUR_W-1:0] game_colour,
  output logic                food_eaten,
  output logic                game_over,
  output logic [5:0]          length,
  output logic                busy
);

  localparam int unsigned PTR_W = $clog2(MAX_LEN);
  localparam int unsigned LEN_W = 6;

  state_t               state_q;
  dir_t                 heading_q;
  coord_t               head_q, new_head_q;
  logic                 grow_q;
  logic [PTR_W-1:0]     head_ptr_q, tail_ptr_q, scan_ptr_q;
  logic [LEN_W-1:0]     length_q, scan_cnt_q;
  logic                 game_plot_q, food_eaten_q, game_over_q, busy_q;
  logic [COORD_W-1:0]   game_x_q, game_y_q;
  logic [COLOUR_W-1:0]  game_colour_q;

  coord_t               food_c, next_head_c, rd_data_c;
  logic                 wall_hit_c, eat_c, grow_c, accept_c, seg_we_c, reversal_c;
  logic [PTR_W-1:0]     rd_addr_c;

  assign food_c      = '{x: food_x, y: food_y};
  assign next_head_c = step_coord(head_q, heading_q);
  assign eat_c       = (next_head_c == food_c);
  assign grow_c      = eat_c && (length_q < LEN_W'(MAX_LEN));
  assign accept_c    = game_plot_q && !plot_waitrequest;
  assign seg_we_c    = accept_c && (state_q == S_DRAW);
  assign reversal_c  = (dir == 2'(heading_q ^ DIR_LEFT));
  // Tail is only read while erasing; init draw and scan share scan_ptr.
  assign rd_addr_c   = (state_q == S_ERASE) ? tail_ptr_q : scan_ptr_q;

`ifdef SNAKE_WALL_DEATH_EN
  assign wall_hit_c = edge_hit(head_q, heading_q);
`else
  assign wall_hit_c = 1'b0;
`endif

  snake_seg_ram #(
    .MAX_LEN  (MAX_LEN),
    .INIT_LEN (INIT_LEN),
    .PTR_W    (PTR_W)
  ) u_seg_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (seg_we_c),
    .waddr_i (head_ptr_q + PTR_W'(1)),
    .wdata_i (new_head_q),
    .raddr_i (rd_addr_c),
    .rdata_o (rd_data_c)
  );

  // Engine FSM with registered plot interface and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RESET_WAIT;
      heading_q     <= DIR_RIGHT;
      head_q        <= '{x: COORD_W'(8), y: COORD_W'(8)};
      new_head_q    <= '0;
      grow_q        <= 1'b0;
      head_ptr_q    <= PTR_W'(INIT_LEN - 1);
      tail_ptr_q    <= '0;
      scan_ptr_q    <= PTR_W'(INIT_LEN - 1);
      scan_cnt_q    <= LEN_W'(INIT_LEN);
      length_q      <= LEN_W'(INIT_LEN);
      game_plot_q   <= 1'b0;
      game_x_q      <= '0;
      game_y_q      <= '0;
      game_colour_q <= '0;
      food_eaten_q  <= 1'b0;
      game_over_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      food_eaten_q <= 1'b0;
      if (dir_valid && !reversal_c) heading_q <= dir_t'(dir);

      case (state_q)
        S_RESET_WAIT: begin
          busy_q <= 1'b1;
          if (start) state_q <= S_INIT_DRAW;
        end

        // Draw the initial body head-first, walking scan_ptr toward the tail.
        S_INIT_DRAW: begin
          if (!game_plot_q) begin
            game_plot_q   <= 1'b1;
            game_x_q      <= rd_data_c.x;
            game_y_q      <= rd_data_c.y;
            game_colour_q <= SNAKE_COLOUR;
          end else if (accept_c) begin
            game_plot_q <= 1'b0;
            scan_ptr_q  <= scan_ptr_q - PTR_W'(1);
            scan_cnt_q  <= scan_cnt_q - LEN_W'(1);
            if (scan_cnt_q == LEN_W'(1)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        S_IDLE: begin
          if (step) begin
            state_q <= S_NEXT;
            busy_q  <= 1'b1;
          end
        end

        // When not growing the tail vacates this step, so it is not scanned.
        S_NEXT: begin
          new_head_q <= next_head_c;
          scan_ptr_q <= head_ptr_q;
          if (wall_hit_c) begin
            state_q     <= S_OVER;
            game_over_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            food_eaten_q <= eat_c;
            grow_q       <= grow_c;
            scan_cnt_q   <= grow_c ? length_q : length_q - LEN_W'(1);
            state_q      <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (rd_data_c == new_head_q) begin
            state_q     <= S_OVER;
            game_over_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            scan_ptr_q <= scan_ptr_q - PTR_W'(1);
            scan_cnt_q <= scan_cnt_q - LEN_W'(1);
            if (scan_cnt_q == LEN_W'(1)) state_q <= grow_q ? S_DRAW : S_ERASE;
          end
        end

        S_ERASE: begin
          if (!game_plot_q) begin
            game_plot_q   <= 1'b1;
            game_x_q      <= rd_data_c.x;
            game_y_q      <= rd_data_c.y;
            game_colour_q <= BG_COLOUR;
          end else if (accept_c) begin
            game_plot_q <= 1'b0;
            tail_ptr_q  <= tail_ptr_q + PTR_W'(1);
            state_q     <= S_DRAW;
          end
        end

        // The segment store is written on the accepting edge (seg_we_c).
        S_DRAW: begin
          if (!game_plot_q) begin
            game_plot_q   <= 1'b1;
            game_x_q      <= new_head_q.x;
            game_y_q      <= new_head_q.y;
            game_colour_q <= SNAKE_COLOUR;
          end else if (accept_c) begin
            game_plot_q <= 1'b0;
            head_ptr_q  <= head_ptr_q + PTR_W'(1);
            head_q      <= new_head_q;
            if (grow_q) length_q <= length_q + LEN_W'(1);
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
          end
        end

        S_OVER: begin
          game_plot_q <= 1'b0;
          game_over_q <= 1'b1;
          busy_q      <= 1'b0;
        end

        default: state_q <= S_RESET_WAIT;
      endcase
    end
  end

  assign game_plot   = game_plot_q;
  assign game_x      = game_x_q;
  assign game_y      = game_y_q;
  assign game_colour = game_colour_q;
  assign food_eaten  = food_eaten_q;
  assign game_over   = game_over_q;
  assign length      = length_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed self-checking bench for snake_engine.
// Expected plot commands, lengths and flags are hand-derived from the
// snake's known body at each point of the scenario.
module tb_snake_engine;

  logic       clk = 1'b0;
  logic       rst, start, step, dir_valid, plot_waitrequest;
  logic [1:0] dir;
  logic [3:0] food_x, food_y;
  logic       game_plot, food_eaten, game_over, busy;
  logic [3:0] game_x, game_y;
  logic [2:0] game_colour;
  logic [5:0] len;

  int n_tests = 0;
  int n_fail  = 0;
  int eat_cnt = 0;

  localparam logic [2:0] SNAKE = 3'b010;
  localparam logic [2:0] BG    = 3'b000;

  always #5 clk = ~clk;

  snake_engine dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .step             (step),
    .dir              (dir),
    .dir_valid        (dir_valid),
    .food_x           (food_x),
    .food_y           (food_y),
    .plot_waitrequest (plot_waitrequest),
    .game_plot        (game_plot),
    .game_x           (game_x),
    .game_y           (game_y),
    .game_colour      (game_colour),
    .food_eaten       (food_eaten),
    .game_over        (game_over),
    .length           (len),
    .busy             (busy)
  );

  always @(posedge clk) if (!rst && food_eaten) eat_cnt <= eat_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait for one plot command, check it, optionally stall it `hold` cycles.
  task automatic wait_cmd(input string tag, input int ex, input int ey, input int ec,
                          input int hold);
    int   n;
    logic stable;
    plot_waitrequest = (hold != 0);
    n = 0;
    while (game_plot !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (game_plot !== 1'b1) begin
      chk({tag, "_timeout"}, 0, 1);
      plot_waitrequest = 1'b0;
      return;
    end
    chk({tag, "_x"}, 32'(game_x), 32'(ex));
    chk({tag, "_y"}, 32'(game_y), 32'(ey));
    chk({tag, "_col"}, 32'(game_colour), 32'(ec));
    if (hold != 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!(game_plot === 1'b1 && game_x == 4'(ex) && game_y == 4'(ey) &&
              game_colour == 3'(ec))) stable = 1'b0;
      end
      chk({tag, "_held"}, 32'(stable), 1);
      plot_waitrequest = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_gap"}, 32'(game_plot), 0);
  endtask

  task automatic do_step();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic set_dir(input logic [1:0] d);
    @(negedge clk);
    dir       = d;
    dir_valid = 1'b1;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic set_food(input int fx, input int fy);
    @(negedge clk);
    food_x = 4'(fx);
    food_y = 4'(fy);
  endtask

  // One step: erase (tx,ty) unless growing, then draw head (hx,hy).
  task automatic move(input string tag, input logic grow, input int tx, input int ty,
                      input int hx, input int hy, input int hold);
    int e0;
    e0 = eat_cnt;
    do_step();
    if (!grow) wait_cmd({tag, "_erase"}, tx, ty, 32'(BG), hold);
    wait_cmd({tag, "_draw"}, hx, hy, 32'(SNAKE), 0);
    chk({tag, "_eaten"}, 32'(eat_cnt - e0), grow ? 1 : 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic no_plot(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (game_plot === 1'b1) seen++;
    end
    chk(tag, 32'(seen), 0);
  endtask

  task automatic reset_and_init(input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_rst_plot"}, 32'(game_plot), 0);
    chk({tag, "_rst_len"}, 32'(len), 3);
    chk({tag, "_rst_over"}, 32'(game_over), 0);
    chk({tag, "_rst_busy"}, 32'(busy), 0);
    chk({tag, "_rst_eaten"}, 32'(food_eaten), 0);
    rst   = 1'b0;
    start = 1'b1;
    wait_cmd({tag, "_init0"}, 8, 8, 32'(SNAKE), 0);
    wait_cmd({tag, "_init1"}, 7, 8, 32'(SNAKE), 0);
    wait_cmd({tag, "_init2"}, 6, 8, 32'(SNAKE), 0);
    chk({tag, "_init_busy"}, 32'(busy), 0);
    chk({tag, "_init_len"}, 32'(len), 3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0; dir = 2'd0; dir_valid = 1'b0;
    plot_waitrequest = 1'b0; food_x = 4'd0; food_y = 4'd15;

    reset_and_init("boot");

    // Plain move right: body (8,8)(7,8)(6,8) -> (9,8)(8,8)(7,8).
    move("mv1", 1'b0, 6, 8, 9, 8, 0);

    // Eat at (10,8): no erase, length grows to 4.
    set_food(10, 8);
    move("eat", 1'b1, 0, 0, 10, 8, 0);
    chk("eat_len", 32'(len), 4);
    set_food(0, 15);

    // Reversal to left is ignored; erase stalled 5 cycles by waitrequest.
    set_dir(2'd2);
    move("rev", 1'b0, 7, 8, 11, 8, 5);
    chk("rev_len", 32'(len), 4);

    // Run to the right edge, then one more step.
    move("e12", 1'b0, 8, 8, 12, 8, 0);
    move("e13", 1'b0, 9, 8, 13, 8, 0);
    move("e14", 1'b0, 10, 8, 14, 8, 0);
    move("e15", 1'b0, 11, 8, 15, 8, 0);
`ifdef SNAKE_WALL_DEATH_EN
    do_step();
    no_plot("wall_noplot", 40);
    chk("wall_over", 32'(game_over), 1);
`else
    move("wrap", 1'b0, 12, 8, 0, 8, 0);
    chk("wrap_over", 32'(game_over), 0);
`endif

    // Grow to 5, then turn down, left, up into own body.
    reset_and_init("sc");
    set_food(9, 8);
    move("g4", 1'b1, 0, 0, 9, 8, 0);
    set_food(10, 8);
    move("g5", 1'b1, 0, 0, 10, 8, 0);
    chk("g5_len", 32'(len), 5);
    set_food(0, 15);
    set_dir(2'd1);
    move("down", 1'b0, 6, 8, 10, 9, 0);
    set_dir(2'd2);
    move("left", 1'b0, 7, 8, 9, 9, 0);
    set_dir(2'd3);
    do_step();
    no_plot("self_noplot", 60);
    chk("self_over", 32'(game_over), 1);
    chk("self_busy", 32'(busy), 0);
    chk("self_len", 32'(len), 5);
    do_step();
    no_plot("over_step_noplot", 30);
    chk("over_sticky", 32'(game_over), 1);

    // Reset while scanning: initial body must come back.
    reset_and_init("pre");
    do_step();
    @(negedge clk);
    chk("midscan_busy", 32'(busy), 1);
    reset_and_init("mid");
    move("mid_mv", 1'b0, 6, 8, 9, 8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
